// File: rtl/demux1to4_buf.sv
// 1-to-4 demultiplexer with a one-entry holding register per output channel.
// Words are steered by select; a full channel accepts only when it drains in the same cycle.
module demux1to4_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       accept_count
);

  logic [3:0]       full_q;
  logic [3:0]       full_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [7:0]       count_q;
  logic [7:0]       count_d;
  logic             accept;
  logic [3:0]       pop;

  always_comb begin
    // A full channel can still take a word if its consumer drains it this cycle.
    in_ready = !full_q[select] || out_ready[select];
    accept   = in_valid && in_ready;
    count_d  = count_q + {7'd0, accept};
    for (int k = 0; k < 4; k++) begin
      pop[k]    = full_q[k] && out_ready[k];
      full_d[k] = full_q[k] && !pop[k];
      data_d[k] = data_q[k];
      if (accept && (select == 2'(k))) begin
        full_d[k] = 1'b1;
        data_d[k] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      full_q  <= full_d;
      count_q <= count_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out1         = data_q[0];
  assign out2         = data_q[1];
  assign out3         = data_q[2];
  assign out4         = data_q[3];
  assign out_valid    = full_q;
  assign accept_count = count_q;

endmodule

// File: tb/tb_demux1to4_buf.sv
// Scoreboard bench for demux1to4_buf: the stimulus pushes expected words per channel,
// a negedge monitor compares the DUT against the per-channel queues.
module tb_demux1to4_buf;
  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out1, out2, out3, out4;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [7:0]       accept_count;

  logic [WIDTH-1:0] outs [4];
  logic [WIDTH-1:0] exp_q [4][$];
  logic [7:0]       exp_cnt;
  int               checks;
  int               errors;

  demux1to4_buf #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .select       (sel),
    .out1         (out1),
    .out2         (out2),
    .out3         (out3),
    .out4         (out4),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .accept_count (accept_count)
  );

  assign outs[0] = out1;
  assign outs[1] = out2;
  assign outs[2] = out3;
  assign outs[3] = out4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; at the edge, record an accept when the target channel is empty
  // in the model (the monitor has already removed any word popped at this edge).
  task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                      input logic [3:0] r);
    in_valid  = v;
    sel       = s;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    if (rst_n && v && exp_q[s].size() == 0) begin
      exp_q[s].push_back(d);
      exp_cnt = exp_cnt + 8'd1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready},
          {31'd0, (exp_q[sel].size() == 0) || out_ready[sel]});
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]},
            {31'd0, exp_q[k].size() != 0});
        if (exp_q[k].size() != 0)
          chk($sformatf("out%0d_data", k + 1), 32'(outs[k]), 32'(exp_q[k][0]));
      end
      chk("accept_count", 32'(accept_count), 32'(exp_cnt));
      for (int k = 0; k < 4; k++) begin
        if (exp_q[k].size() != 0 && out_ready[k]) void'(exp_q[k].pop_front());
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    exp_cnt   = 8'd0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    sel       = 2'd0;
    in_data   = '0;
    out_ready = 4'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(accept_count), 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out1", 32'(out1), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Routing to all four channels with no consumer
    step(1'b1, 2'd0, 4'd5, 4'b0000);
    step(1'b1, 2'd1, 4'd1, 4'b0000);
    step(1'b1, 2'd2, 4'd4, 4'b0000);
    step(1'b1, 2'd3, 4'd3, 4'b0000);
    chk("route_out1", 32'(out1), 32'd5);
    chk("route_out2", 32'(out2), 32'd1);
    chk("route_out3", 32'(out3), 32'd4);
    chk("route_out4", 32'(out4), 32'd3);
    chk("route_valid", 32'(out_valid), 32'hf);
    chk("route_count", 32'(accept_count), 32'd4);

    // Backpressure on channel 1, then release
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 4'd9, 4'b0000);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out1_held", 32'(out1), 32'd5);
    step(1'b1, 2'd0, 4'd9, 4'b0001);
    chk("bp_out1_new", 32'(out1), 32'd9);
    chk("bp_valid_held", {31'd0, out_valid[0]}, 32'd1);

    // Blocked channel 1 does not stop a word for channel 3
    step(1'b1, 2'd0, 4'd6, 4'b0000);
    step(1'b1, 2'd2, 4'd7, 4'b0100);
    chk("indep_out3", 32'(out3), 32'd7);
    chk("indep_out1", 32'(out1), 32'd9);

    // Asynchronous reset between edges with every channel full
    in_valid = 1'b0;
    out_ready = 4'd0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_outs", {16'd0, 4'(out1), 4'(out2), 4'(out3), 4'(out4)}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_count", 32'(accept_count), 32'd0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    exp_cnt = 8'd0;
    #1 rst_n = 1'b1;

    // Streaming through a draining channel 1
    for (int i = 0; i < 10; i++) step(1'b1, 2'd0, 4'(i), 4'b0001);
    chk("stream_count", 32'(accept_count), 32'd10);
    chk("stream_out1", 32'(out1), 32'd9);

    // Counter wrap after 256 accepts
    for (int i = 10; i < 256; i++) step(1'b1, 2'd0, 4'(i), 4'b0001);
    chk("wrap_count", 32'(accept_count), 32'd0);
    chk("wrap_out1", 32'(out1), 32'd15);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    step(1'b0, 2'd0, 4'd0, 4'b1111);
    step(1'b0, 2'd0, 4'd0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1to4_buf.md
DEMUX1TO4_BUF -- requirements
Module: demux1to4_buf

Interface
REQ-001 Parameter WIDTH, default 4, is the data width of the input and of every output channel.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; the block SHALL use one clock, and reset is asynchronous and active-low.
REQ-004 in_valid  input  1  producer presents a word on in_data.
REQ-005 in_ready  output  1  block accepts the presented word this cycle.
REQ-006 in_data  input  WIDTH  input word.
REQ-007 select  input  2  destination channel: 2'b00 -> out1, 01 -> out2, 10 -> out3, 11 -> out4.
REQ-008 out1, out2, out3, out4  output  WIDTH  channel data, each driven from that channel's holding register.
REQ-009 out_valid  output  4  bit k-1 high when channel k (k = 1..4) holds a word.
REQ-010 out_ready  input  4  bit k-1 high when channel k's consumer takes the word this cycle.
REQ-011 accept_count  output  8  running count of accepted input words.

Function
REQ-012 Each channel SHALL have a one-entry holding register (data plus full flag); out_valid[k-1] SHALL equal full[k-1], and outk SHALL equal the channel's data register.
REQ-013 in_ready SHALL be combinational: in_ready = !full[select] || out_ready[select]. It SHALL NOT depend on in_valid.
REQ-014 An accept occurs on a rising edge where in_valid && in_ready; the word SHALL be written to the channel named by select; full for that channel SHALL be 1 after the edge.
REQ-015 A pop occurs on channel k at a rising edge where full[k-1] && out_ready[k-1]; full SHALL clear unless the same edge accepts into channel k.
REQ-016 A simultaneous pop and accept on the same channel SHALL replace the data with the new word and keep full = 1, with no bubble.
REQ-017 Pops on other channels in the same cycle SHALL proceed independently of the accept.
REQ-018 Latency SHALL be 1 cycle: a word accepted at edge N SHALL appear on outk with out_valid high after edge N.
REQ-019 A full channel SHALL NOT be overwritten without a same-cycle pop. When select targets a full, non-draining channel, in_ready SHALL be 0 and the word SHALL be held upstream.
REQ-020 A blocked channel SHALL NOT block words aimed at other channels when select changes.
REQ-021 select and in_data SHALL be sampled only on accepting edges; changes while in_valid = 0 SHALL have no effect.
REQ-022 outk and out_valid SHALL be stable while full && !out_ready; data SHALL never change under a held valid.
REQ-023 accept_count SHALL increment by 1 on every accept, and SHALL wrap from 8'd255 to 8'd0.
REQ-024 out_ready on an empty channel SHALL be ignored.

Reset
REQ-025 While rst_n = 0, independent of clk, the block SHALL hold all full flags = 0, all channel data = 0, and accept_count = 0, so out_valid = 4'b0000 and out1..out4 = 0.
REQ-026 During reset and immediately after release, in_ready SHALL be 1, because all channels are empty.
REQ-027 Reset asserted mid-operation SHALL discard every held word, with no pop reported.
REQ-028 The first edge after deassertion SHALL be able to accept a word.

Verification
REQ-029 Routing: rst_n pulse; then send 4'b0101 sel 00, 4'b0001 sel 01, 4'b0100 sel 10, 4'b0011 sel 11 with out_ready = 0 -> out1..out4 = 5, 1, 4, 3, out_valid = 4'b1111, accept_count = 4.
REQ-030 Backpressure: channel 1 full, out_ready = 0, in_valid = 1, sel 00 -> in_ready = 0 and out1 unchanged for 3 cycles; then out_ready[0] = 1 -> in_ready = 1 and the new word is on out1 the next cycle, valid held.
REQ-031 Independence: channel 1 full and blocked, sel switched to 10 -> in_ready = 1 and the word lands on out3; out1 is untouched.
REQ-032 Streaming: out_ready = 4'b0001, sel 00, in_valid high for 10 cycles with data 0..9 -> one word accepted per cycle, out1 follows the data one cycle later, accept_count = 10.
REQ-033 Wrap: 256 accepts -> accept_count = 0 and the channel contents are correct.
REQ-034 Async reset: rst_n asserted between edges with all channels full -> out_valid = 4'b0000, outputs 0 and in_ready = 1 before the next clk edge.
